user_stream_fifo: RTL and testbench
===================================

USER_STREAM_FIFO -- requirements
Module: user_stream_fifo

Interface
REQ-001 SHALL have parameter PAYLOAD_BITS, default 32, width of one user-stream word.
REQ-002 SHALL have parameter DEPTH_BITS, default 4, log2 of storage depth (DEPTH = 2^DEPTH_BITS entries).
REQ-003 SHALL have port clk_user  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port din  input  PAYLOAD_BITS  word from the upstream leaf interface user output.
REQ-006 SHALL have port din_vld  input  1  upstream word valid.
REQ-007 SHALL have port din_ack  output  1  word accepted this cycle.
REQ-008 SHALL have port dout  output  PAYLOAD_BITS  head word presented to the downstream operator Input port.
REQ-009 SHALL have port dout_vld  output  1  head word valid (drives the operator ap_vld).
REQ-010 SHALL have port dout_ack  input  1  operator consumed head word (from the operator ap_ack).
REQ-011 SHALL have port count  output  DEPTH_BITS+1  current occupancy, 0..DEPTH.
REQ-012 SHALL have port max_count  output  DEPTH_BITS+1  highest occupancy since reset (watermark).

Function
REQ-013 SHALL define a push as din_vld=1 and din_ack=1 in the same cycle, and a pop as dout_vld=1 and dout_ack=1 in the same cycle.
REQ-014 SHALL drive din_ack combinationally as din_vld AND (count < DEPTH) AND NOT reset.
REQ-015 SHALL drive din_ack=0 when full (count=DEPTH), even if a pop occurs in the same cycle; no full pass-through.
REQ-016 SHALL drive dout_vld = (count != 0), registered-state derived, with no combinational path from din_vld.
REQ-017 SHALL drive dout from the entry at the read pointer; dout SHALL remain stable while dout_vld=1 and dout_ack=0.
REQ-018 SHALL have a write-to-read latency of exactly 1 cycle: a word pushed in cycle N into an empty FIFO appears with dout_vld=1 in cycle N+1; no same-cycle bypass.
REQ-019 SHALL ignore dout_ack while dout_vld=0 (no pointer or count change).
REQ-020 SHALL use DEPTH_BITS-wide read and write pointers that wrap from DEPTH-1 to 0.
REQ-021 SHALL update count by +1 on push only, -1 on pop only, and leave it unchanged on simultaneous push and pop.
REQ-022 SHALL preserve strict FIFO order; no word is dropped or duplicated.
REQ-023 SHALL update max_count to the next-cycle count whenever that exceeds the current max_count; max_count never decreases except on reset.
REQ-024 SHALL contain no state machine beyond the pointers, count and watermark; storage contents need no reset.

Reset
REQ-025 SHALL, in any cycle with reset=1, clear read pointer, write pointer, count and max_count to 0 at the next edge, discarding stored words.
REQ-026 SHALL output dout_vld=0, din_ack=0, count=0 and max_count=0 in the first cycle after reset is sampled high, and hold these while reset remains high.
REQ-027 SHALL treat reset asserted mid-transfer as dominant: a push or pop requested in the reset cycle has no effect.

Verification
REQ-028 Bench SHALL cover: reset, then din=0x00000011 with din_vld=1 for one cycle, dout_ack=0 -> cycle after push dout=0x00000011, dout_vld=1, count=1, held stable until dout_ack=1.
REQ-029 Bench SHALL cover: push 16 words 0..15 with DEPTH_BITS=4 and dout_ack=0 -> count=16, din_ack=0 on the 17th attempt, max_count=16; then drain -> words exit 0..15 in order, count returns to 0, max_count stays 16.
REQ-030 Bench SHALL cover: full FIFO with din_vld=1 and dout_ack=1 in the same cycle -> pop only, count 16->15, din_ack=0 in that cycle; push accepted in the next cycle.
REQ-031 Bench SHALL cover: steady streaming with din_vld=1 and dout_ack=1 for 40 cycles -> count stays at 1 after the first cycle, pointers wrap at least twice, and the output sequence equals the input sequence.
REQ-032 Bench SHALL cover: reset asserted for one cycle with count=5 and din_vld=1 -> next cycle count=0, dout_vld=0, max_count=0, and the word offered in the reset cycle is never output.
REQ-033 Bench SHALL cover: dout_ack=1 while empty -> count stays 0 and the next pushed word is output unchanged.

Source files
------------

// File: rtl/user_stream_fifo.sv
// user_stream_fifo: single-clock stream FIFO between a leaf user output and an operator input,
// with occupancy count and a high-water mark.
module user_stream_fifo #(
    parameter int PAYLOAD_BITS = 32,
    parameter int DEPTH_BITS   = 4
) (
    input  logic                    clk_user,
    input  logic                    reset,
    input  logic [PAYLOAD_BITS-1:0] din,
    input  logic                    din_vld,
    output logic                    din_ack,
    output logic [PAYLOAD_BITS-1:0] dout,
    output logic                    dout_vld,
    input  logic                    dout_ack,
    output logic [DEPTH_BITS:0]     count,
    output logic [DEPTH_BITS:0]     max_count
);
    localparam int DEPTH = 1 << DEPTH_BITS;

    logic [PAYLOAD_BITS-1:0] mem_q [DEPTH];
    logic [DEPTH_BITS-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [DEPTH_BITS:0]     count_q, count_d, max_q, max_d;
    logic                    push, pop;

    // count never exceeds DEPTH, so its MSB alone flags full
    assign din_ack   = din_vld && !count_q[DEPTH_BITS] && !reset;
    assign dout_vld  = count_q != '0;
    assign dout      = mem_q[rd_ptr_q];
    assign count     = count_q;
    assign max_count = max_q;
    assign push      = din_ack;
    assign pop       = dout_vld && dout_ack;

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + DEPTH_BITS'(1) : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + DEPTH_BITS'(1) : rd_ptr_q;
        count_d  = count_q + (DEPTH_BITS+1)'(push) - (DEPTH_BITS+1)'(pop);
        max_d    = count_d > max_q ? count_d : max_q;
    end

    always_ff @(posedge clk_user) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            max_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            max_q    <= max_d;
        end
    end

    always_ff @(posedge clk_user) begin
        if (push) mem_q[wr_ptr_q] <= din;
    end
endmodule

// File: tb/tb_user_stream_fifo.sv
// tb_user_stream_fifo: directed and random stimulus checked against a queue model of the FIFO.
module tb_user_stream_fifo;
    localparam int DEPTH = 16;

    logic        clk_user = 1'b0;
    logic        reset;
    logic [31:0] din;
    logic        din_vld;
    logic        din_ack;
    logic [31:0] dout;
    logic        dout_vld;
    logic        dout_ack;
    logic [4:0]  count;
    logic [4:0]  max_count;

    int          n_checks = 0;
    int          n_fails  = 0;
    logic [31:0] q[$];
    int          mx = 0;

    user_stream_fifo dut (
        .clk_user (clk_user),
        .reset    (reset),
        .din      (din),
        .din_vld  (din_vld),
        .din_ack  (din_ack),
        .dout     (dout),
        .dout_vld (dout_vld),
        .dout_ack (dout_ack),
        .count    (count),
        .max_count(max_count)
    );

    always #5 clk_user = ~clk_user;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive at negedge, check against the model, then advance the model.
    task automatic cycle(input logic vld, input logic [31:0] d, input logic ack, input logic rst);
        logic exp_ack, exp_vld;
        @(negedge clk_user);
        din_vld = vld; din = d; dout_ack = ack; reset = rst;
        #1;
        exp_ack = vld && q.size() < DEPTH && !rst;
        exp_vld = q.size() != 0;
        chk("din_ack", 32'(din_ack), 32'(exp_ack));
        chk("dout_vld", 32'(dout_vld), 32'(exp_vld));
        chk("count", 32'(count), 32'(q.size()));
        chk("max_count", 32'(max_count), 32'(mx));
        if (exp_vld) chk("dout", dout, q[0]);
        if (rst) begin
            q.delete();
            mx = 0;
        end else begin
            if (exp_vld && ack) void'(q.pop_front());
            if (exp_ack) q.push_back(d);
            if (q.size() > mx) mx = q.size();
        end
    endtask

    initial begin
        reset = 1'b1; din_vld = 1'b0; din = '0; dout_ack = 1'b0;
        @(posedge clk_user);
        cycle(0, 0, 0, 1);
        cycle(1, 32'h77, 1, 1);
        // single word, held until acknowledged
        cycle(0, 0, 0, 0);
        cycle(1, 32'h11, 0, 0);
        repeat (3) cycle(0, 0, 0, 0);
        cycle(0, 0, 1, 0);
        cycle(0, 0, 0, 0);
        // fill to full, refused 17th, pop while full, refill, drain
        for (int i = 0; i < DEPTH; i++) cycle(1, 32'(i), 0, 0);
        cycle(1, 32'd16, 0, 0);
        cycle(1, 32'd99, 1, 0);
        cycle(1, 32'd100, 0, 0);
        repeat (DEPTH + 2) cycle(0, 0, 1, 0);
        // ack while empty is ignored
        cycle(0, 0, 1, 0);
        cycle(0, 0, 1, 0);
        cycle(1, 32'h55, 1, 0);
        cycle(0, 0, 1, 0);
        // steady streaming
        for (int i = 0; i < 40; i++) cycle(1, $urandom, 1, 0);
        repeat (2) cycle(0, 0, 1, 0);
        // reset with occupancy 5 and a word offered
        for (int i = 0; i < 5; i++) cycle(1, 32'h100 + 32'(i), 0, 0);
        cycle(1, 32'hdead, 0, 1);
        cycle(0, 0, 0, 0);
        cycle(1, 32'h200, 0, 0);
        repeat (2) cycle(0, 0, 1, 0);
        // random traffic with occasional reset
        for (int i = 0; i < 400; i++)
            cycle(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) == 0),
                  1'($urandom_range(0, 60) == 0));
        for (int i = 0; i < 200; i++)
            cycle(1'($urandom_range(0, 2) == 0), $urandom, 1'($urandom_range(0, 3) != 0), 1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
